// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
// rr_pick works on a fixed 8-bit request vector, which covers the 2..8 port range.
package obi_arb_pkg;

    localparam int unsigned OBI_BE_WIDTH   = 4;
    localparam int unsigned OBI_ADDR_WIDTH = 32;
    localparam int unsigned OBI_DATA_WIDTH = 32;
    localparam int unsigned OBI_MAX_REQ    = 8;
    localparam int unsigned OBI_REQ_IDX_W  = 3;

    // One initiator's address-phase bundle at the SoC's native widths.
    typedef struct packed {
        logic [OBI_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [OBI_BE_WIDTH-1:0]   be;
        logic [OBI_DATA_WIDTH-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                     found;
        logic [OBI_REQ_IDX_W-1:0] idx;
    } rr_pick_t;

    // Returns the first asserted request at or above ptr, wrapping modulo num.
    // Fixed priority is the same search with ptr tied to zero.
    function automatic rr_pick_t rr_pick(input logic [OBI_MAX_REQ-1:0]   req,
                                         input logic [OBI_REQ_IDX_W-1:0] ptr,
                                         input int unsigned              num);
        rr_pick_t    res;
        int unsigned k;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned i = 0; i < OBI_MAX_REQ; i++) begin
            if (i < num) begin
                k = 32'(ptr) + i;
                if (k >= num) begin
                    k = k - num;
                end
                if (!res.found && req[k[OBI_REQ_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = k[OBI_REQ_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of initiator indices, one entry per granted but unanswered
// transaction. Occupancy is tracked with a counter; pointers wrap at DEPTH.
module obi_arb_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI target among NUM_REQ initiators.
// A pending address phase is locked until granted; responses are routed back
// in order through an ID FIFO.
// Define OBI_ARB_FIXED_PRIO_EN for lowest-index-wins selection (no rr pointer).
// While locked, the target request follows the locked initiator's req, so an
// initiator withdrawing early drops t_req_o, releases the lock and flags err_o.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_i,
    output logic [NUM_REQ-1:0]                 gnt_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      addr_i,
    input  logic [NUM_REQ-1:0]                 we_i,
    input  logic [NUM_REQ*OBI_BE_WIDTH-1:0]    be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      wdata_i,
    output logic [NUM_REQ-1:0]                 rvalid_o,
    output logic [DATA_WIDTH-1:0]              rdata_o,
    output logic                               t_req_o,
    input  logic                               t_gnt_i,
    output logic [ADDR_WIDTH-1:0]              t_addr_o,
    output logic                               t_we_o,
    output logic [OBI_BE_WIDTH-1:0]            t_be_o,
    output logic [DATA_WIDTH-1:0]              t_wdata_o,
    input  logic                               t_rvalid_i,
    input  logic [DATA_WIDTH-1:0]              t_rdata_i,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             err_q;
    logic [IDX_W-1:0] ptr;
    rr_pick_t         pick;
    logic [IDX_W-1:0] winner;
    logic             sel_req;
    logic             grant;
    logic             fifo_push;
    logic             fifo_pop;
    logic [IDX_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef OBI_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q;

    assign ptr = rr_ptr_q;

    // Advance the round-robin pointer past each granted initiator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (grant) begin
            rr_ptr_q <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    // Pick the winner: the locked index if an address phase is pending, else a fresh search.
    always_comb begin
        pick    = rr_pick(OBI_MAX_REQ'(req_i), OBI_REQ_IDX_W'(ptr), NUM_REQ);
        winner  = lock_q ? lock_idx_q : IDX_W'(pick.idx);
        sel_req = lock_q ? req_i[lock_idx_q] : pick.found;
    end

    assign t_req_o   = sel_req && !fifo_full;
    assign grant     = t_req_o && t_gnt_i;
    assign fifo_push = grant;
    assign fifo_pop  = t_rvalid_i && !fifo_empty;
    assign rdata_o   = t_rdata_i;
    assign busy_o    = !fifo_empty || t_req_o;
    assign err_o     = err_q;

    // Address-phase mux plus one-hot grant and response routing; all zero when idle.
    always_comb begin
        t_addr_o  = '0;
        t_we_o    = 1'b0;
        t_be_o    = '0;
        t_wdata_o = '0;
        gnt_o     = '0;
        rvalid_o  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (t_req_o && (winner == IDX_W'(k))) begin
                t_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                t_we_o    = we_i[k];
                t_be_o    = be_i[k*OBI_BE_WIDTH +: OBI_BE_WIDTH];
                t_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                gnt_o[k]  = grant;
            end
            if (fifo_pop && (fifo_dout == IDX_W'(k))) begin
                rvalid_o[k] = 1'b1;
            end
        end
    end

    // Lock a stalled address phase and keep a sticky record of protocol violations.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q <= t_req_o && !t_gnt_i;
            if (t_req_o && !t_gnt_i) begin
                lock_idx_q <= winner;
            end
            if ((t_rvalid_i && fifo_empty) || (lock_q && !req_i[lock_idx_q])) begin
                err_q <= 1'b1;
            end
        end
    end

    obi_arb_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (winner),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios followed by
// randomized OBI-compliant traffic, all checked against a transaction-level model.
module tb_obi_rr_arbiter;
    import obi_arb_pkg::*;

    localparam int NUM  = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [NUM-1:0]         req_i;
    logic [NUM-1:0]         gnt_o;
    logic [NUM*AW-1:0]      addr_i;
    logic [NUM-1:0]         we_i;
    logic [NUM*4-1:0]       be_i;
    logic [NUM*DW-1:0]      wdata_i;
    logic [NUM-1:0]         rvalid_o;
    logic [DW-1:0]          rdata_o;
    logic                   t_req_o;
    logic                   t_gnt_i;
    logic [AW-1:0]          t_addr_o;
    logic                   t_we_o;
    logic [3:0]             t_be_o;
    logic [DW-1:0]          t_wdata_o;
    logic                   t_rvalid_i;
    logic [DW-1:0]          t_rdata_i;
    logic                   busy_o;
    logic                   err_o;

    obi_rr_arbiter #(
        .NUM_REQ         (NUM),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .t_req_o    (t_req_o),
        .t_gnt_i    (t_gnt_i),
        .t_addr_o   (t_addr_o),
        .t_we_o     (t_we_o),
        .t_be_o     (t_be_o),
        .t_wdata_o  (t_wdata_o),
        .t_rvalid_i (t_rvalid_i),
        .t_rdata_i  (t_rdata_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int       checks = 0;
    int       fails  = 0;
    obi_req_t port_req [NUM];

    // Reference model: queue of issuers awaiting a response, next-favoured port,
    // pending (stalled) address phase, sticky error.
    int       q [$];
    int       m_rr;
    bit       m_lock;
    int       m_lock_idx;
    bit       m_err;
    int       m_win;
    bit       m_treq;
    bit       m_grant;
    bit       m_pop;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic randomizePayload(input int p);
        port_req[p].addr  = $urandom();
        port_req[p].we    = 1'($urandom_range(0, 1));
        port_req[p].be    = 4'($urandom_range(0, 15));
        port_req[p].wdata = $urandom();
    endtask

    task automatic driveBuses();
        for (int p = 0; p < NUM; p++) begin
            addr_i[p*AW +: AW]   = port_req[p].addr;
            we_i[p]              = port_req[p].we;
            be_i[p*4 +: 4]       = port_req[p].be;
            wdata_i[p*DW +: DW]  = port_req[p].wdata;
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_rr   = 0;
        m_lock = 0;
        m_lock_idx = 0;
        m_err  = 0;
    endtask

    // Evaluate this cycle's expected behaviour and compare every output.
    task automatic checkModel();
        logic [NUM-1:0] exp_gnt;
        logic [NUM-1:0] exp_rv;
        bit             found;
        bit             full;
        full  = (q.size() == MAXO);
        found = 0;
        m_win = 0;
        if (m_lock) begin
            m_win = m_lock_idx;
            found = req_i[m_win];
        end else begin
            for (int i = 0; i < NUM; i++) begin
                int k = (m_rr + i) % NUM;
                if (!found && req_i[k]) begin
                    found = 1;
                    m_win = k;
                end
            end
        end
        m_treq  = found && !full;
        m_grant = m_treq && t_gnt_i;
        m_pop   = t_rvalid_i && (q.size() > 0);
        exp_gnt = '0;
        exp_rv  = '0;
        if (m_grant) exp_gnt[m_win] = 1'b1;
        if (m_pop) exp_rv[q[0]] = 1'b1;
        checkOutput("gnt",     64'(gnt_o),     64'(exp_gnt));
        checkOutput("t_req",   64'(t_req_o),   64'(m_treq));
        checkOutput("t_addr",  64'(t_addr_o),  m_treq ? 64'(port_req[m_win].addr)  : 64'd0);
        checkOutput("t_we",    64'(t_we_o),    m_treq ? 64'(port_req[m_win].we)    : 64'd0);
        checkOutput("t_be",    64'(t_be_o),    m_treq ? 64'(port_req[m_win].be)    : 64'd0);
        checkOutput("t_wdata", 64'(t_wdata_o), m_treq ? 64'(port_req[m_win].wdata) : 64'd0);
        checkOutput("rvalid",  64'(rvalid_o),  64'(exp_rv));
        checkOutput("rdata",   64'(rdata_o),   64'(t_rdata_i));
        checkOutput("busy",    64'(busy_o),    64'((q.size() > 0) || m_treq));
        checkOutput("err",     64'(err_o),     64'(m_err));
    endtask

    // Called just after a rising edge: drive inputs, then check mid-cycle.
    task automatic applyStimulus(input logic [NUM-1:0] req, input logic gnt,
                                 input logic rvalid, input logic [DW-1:0] rdata);
        req_i      = req;
        t_gnt_i    = gnt;
        t_rvalid_i = rvalid;
        t_rdata_i  = rdata;
        driveBuses();
        @(negedge clk_i);
        checkModel();
    endtask

    // Close the cycle: clock edge, then advance the model.
    task automatic endCycle();
        @(posedge clk_i);
        if (t_rvalid_i && !m_pop) m_err = 1;
        if (m_lock && !req_i[m_lock_idx]) m_err = 1;
        if (m_pop) void'(q.pop_front());
        if (m_grant) begin
            q.push_back(m_win);
            m_rr = (m_win + 1) % NUM;
        end
        if (m_treq && !t_gnt_i) begin
            m_lock     = 1;
            m_lock_idx = m_win;
        end else begin
            m_lock = 0;
        end
        #1;
    endtask

    task automatic doReset();
        req_i      = '0;
        t_gnt_i    = 1'b0;
        t_rvalid_i = 1'b0;
        t_rdata_i  = '0;
        driveBuses();
        rst_ni     = 1'b0;
        #2;
        checkOutput("rst_gnt",    64'(gnt_o),    64'd0);
        checkOutput("rst_t_req",  64'(t_req_o),  64'd0);
        checkOutput("rst_t_addr", 64'(t_addr_o), 64'd0);
        checkOutput("rst_rvalid", 64'(rvalid_o), 64'd0);
        checkOutput("rst_busy",   64'(busy_o),   64'd0);
        checkOutput("rst_err",    64'(err_o),    64'd0);
        modelReset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        int             t1_gnt [4];
        int             t1_rv  [4];
        logic [NUM-1:0] pending;

        t1_gnt = '{1, 2, 1, 2};
        t1_rv  = '{0, 1, 2, 1};
        rst_ni = 1'b0;
        for (int p = 0; p < NUM; p++) randomizePayload(p);
        doReset();

        // Round-robin fairness with responses trailing grants by one cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 1'b1, (i > 0), $urandom());
            checkOutput("t1_gnt",    64'(gnt_o),    64'(t1_gnt[i]));
            checkOutput("t1_rvalid", 64'(rvalid_o), 64'(t1_rv[i]));
            endCycle();
        end
        applyStimulus(2'b00, 1'b0, 1'b1, $urandom());
        checkOutput("t1_drain", 64'(rvalid_o), 64'd2);
        endCycle();

        // Response routing: port1 then port0 granted, answered in order.
        applyStimulus(2'b10, 1'b1, 1'b0, '0);
        checkOutput("t4_gnt1", 64'(gnt_o), 64'd2);
        endCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        checkOutput("t4_gnt0", 64'(gnt_o), 64'd1);
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("t4_rv1",    64'(rvalid_o), 64'd2);
        checkOutput("t4_rdata1", 64'(rdata_o),  64'hDEAD_BEEF);
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h1234_5678);
        checkOutput("t4_rv0",    64'(rvalid_o), 64'd1);
        checkOutput("t4_rdata0", 64'(rdata_o),  64'h1234_5678);
        endCycle();

        // Lock stability: port0 stalled while port1 (now favoured) also requests.
        port_req[0].addr = 32'h0010_0040;
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0, '0);
            checkOutput("t2_addr", 64'(t_addr_o), 64'h0010_0040);
            checkOutput("t2_nogn", 64'(gnt_o),    64'd0);
            endCycle();
        end
        applyStimulus(2'b11, 1'b1, 1'b0, '0);
        checkOutput("t2_gnt0", 64'(gnt_o), 64'd1);
        endCycle();
        applyStimulus(2'b10, 1'b1, 1'b0, '0);
        checkOutput("t2_gnt1", 64'(gnt_o), 64'd2);
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, $urandom());
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, $urandom());
        endCycle();

        // FIFO full: third request held; a pop frees space only from the next cycle.
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        endCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        endCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        checkOutput("t3_full_req", 64'(t_req_o), 64'd0);
        checkOutput("t3_full_gnt", 64'(gnt_o),   64'd0);
        endCycle();
        applyStimulus(2'b01, 1'b1, 1'b1, $urandom());
        checkOutput("t3_pop_req", 64'(t_req_o), 64'd0);
        endCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        checkOutput("t3_after_req", 64'(t_req_o), 64'd1);
        checkOutput("t3_after_gnt", 64'(gnt_o),   64'd1);
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, $urandom());
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, $urandom());
        endCycle();

        // Response with nothing outstanding is dropped and flags a sticky error.
        applyStimulus(2'b00, 1'b0, 1'b1, 32'hCAFE_0001);
        checkOutput("t5_rvalid", 64'(rvalid_o), 64'd0);
        endCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0, '0);
            checkOutput("t5_err", 64'(err_o), 64'd1);
            endCycle();
        end
        doReset();

        // Initiator withdrawing a stalled request drops t_req_o and flags an error.
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t7_req_drop", 64'(t_req_o), 64'd0);
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("t7_err", 64'(err_o), 64'd1);
        endCycle();

        // Reset with two IDs outstanding, then port0 wins first again.
        applyStimulus(2'b11, 1'b1, 1'b0, '0);
        endCycle();
        applyStimulus(2'b11, 1'b1, 1'b0, '0);
        endCycle();
        doReset();
        applyStimulus(2'b11, 1'b1, 1'b0, '0);
        checkOutput("t6_first_gnt", 64'(gnt_o), 64'd1);
        endCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, $urandom());
        checkOutput("t6_rvalid", 64'(rvalid_o), 64'd1);
        endCycle();

        // Randomized compliant traffic: requests held until granted, responses in order.
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NUM; p++) begin
                if (!pending[p] && ($urandom_range(0, 1) == 1)) begin
                    pending[p] = 1'b1;
                    randomizePayload(p);
                end
            end
            applyStimulus(pending, ($urandom_range(0, 2) != 0),
                          (q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom());
            if (m_grant) pending[m_win] = 1'b0;
            endCycle();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
